// File: rtl/instr_fetch_buffer_if.sv
// Handshake bundle between the instruction loader/dispatch side and the fetch buffer.
// The master drives loader writes, dispatch pops and flush; the slave is the buffer itself.
interface instr_fetch_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          flush;
  logic          wr_valid;
  logic [31:0]   wr_instr;
  logic          wr_ready;
  logic          dispatch_1_ready;
  logic          dispatch_2_ready;
  logic [31:0]   instr1;
  logic [31:0]   instr2;
  logic          instr1_valid;
  logic          instr2_valid;
  logic          instr_queue_empty;
  logic [AW:0]   count;
  logic [15:0]   pair_issues;

  modport master (
    output flush, wr_valid, wr_instr, dispatch_1_ready, dispatch_2_ready,
    input  wr_ready, instr1, instr2, instr1_valid, instr2_valid,
           instr_queue_empty, count, pair_issues
  );

  modport slave (
    input  flush, wr_valid, wr_instr, dispatch_1_ready, dispatch_2_ready,
    output wr_ready, instr1, instr2, instr1_valid, instr2_valid,
           instr_queue_empty, count, pair_issues
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Show-ahead instruction FIFO presenting up to two in-order words per cycle to the
// dispatch units; flush discards contents, pair_issues counts dual-issue cycles.
module instr_fetch_buffer #(
  parameter int          DEPTH = 16,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   pair_q, pair_d;
  logic          valid1, valid2, wr_ready_w;
  logic          push, pop1, pop2;

  assign valid1     = (count_q != '0);
  assign valid2     = (count_q >= (AW+1)'(2));
  // Space is judged on held entries only, so a pop on a full cycle cannot admit a write.
  assign wr_ready_w = (count_q != (AW+1)'(DEPTH));

  assign push = bus.wr_valid && wr_ready_w;
  assign pop1 = bus.dispatch_1_ready && valid1;
  assign pop2 = pop1 && bus.dispatch_2_ready && valid2;

  assign rd_ptr_nxt = rd_ptr_q + AW'(1);

  assign bus.wr_ready          = wr_ready_w;
  assign bus.instr1_valid      = valid1;
  assign bus.instr2_valid      = valid2;
  assign bus.instr_queue_empty = !valid1;
  assign bus.instr1            = valid1 ? mem_q[rd_ptr_q]   : NOP;
  assign bus.instr2            = valid2 ? mem_q[rd_ptr_nxt] : NOP;
  assign bus.count             = count_q;
  assign bus.pair_issues       = pair_q;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pair_d   = pair_q;
    if (bus.flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop1) - (AW+1)'(pop2);
      rd_ptr_d = rd_ptr_q + AW'(pop1) + AW'(pop2);
      wr_ptr_d = wr_ptr_q + AW'(push);
      if (pop2 && (pair_q != 16'hFFFF)) begin
        pair_d = pair_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pair_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pair_q   <= pair_d;
    end
  end

  // Storage carries no reset; validity comes entirely from count_q.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_q[wr_ptr_q] <= bus.wr_instr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: accepted writes are queued as expected words,
// a negedge monitor compares the presented outputs and retires entries on pops.
module tb_instr_fetch_buffer;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst_n;

  instr_fetch_buffer_if #(.DEPTH(DEPTH)) bus();

  instr_fetch_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          mpair;
  int          n;
  logic        p1, p2, ps;
  int          pexp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush            = 1'b0;
    bus.wr_valid         = 1'b0;
    bus.dispatch_1_ready = 1'b0;
    bus.dispatch_2_ready = 1'b0;
  endtask

  task automatic fill(input int k);
    idle();
    for (int i = 0; i < k; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_instr = $urandom;
      cyc();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    bus.dispatch_1_ready = 1'b1;
    bus.dispatch_2_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) cyc();
    idle();
  endtask

  // Reference model: expected words live in mq in arrival order; inputs are stable at negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      n = mq.size();
      chk("count",       32'(bus.count),         n);
      chk("instr1",      bus.instr1,             (n >= 1) ? mq[0] : NOP);
      chk("instr2",      bus.instr2,             (n >= 2) ? mq[1] : NOP);
      chk("instr1_valid", 32'(bus.instr1_valid), 32'(n >= 1));
      chk("instr2_valid", 32'(bus.instr2_valid), 32'(n >= 2));
      chk("empty",       32'(bus.instr_queue_empty), 32'(n == 0));
      chk("wr_ready",    32'(bus.wr_ready),      32'(n != DEPTH));
      chk("pair_issues", 32'(bus.pair_issues),   mpair);
      if (bus.flush) begin
        mq.delete();
      end else begin
        p1 = bus.dispatch_1_ready && (n >= 1);
        p2 = p1 && bus.dispatch_2_ready && (n >= 2);
        ps = bus.wr_valid && (n < DEPTH);
        if (p1) void'(mq.pop_front());
        if (p2) void'(mq.pop_front());
        if (ps) mq.push_back(bus.wr_instr);
        if (p2 && mpair < 65535) mpair++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mpair = 0;
    bus.wr_instr = '0;
    idle();
    #12;
    chk("rst count",  32'(bus.count), 0);
    chk("rst wr_ready", 32'(bus.wr_ready), 1);
    chk("rst empty",  32'(bus.instr_queue_empty), 1);
    chk("rst v1",     32'(bus.instr1_valid), 0);
    chk("rst v2",     32'(bus.instr2_valid), 0);
    chk("rst instr1", bus.instr1, NOP);
    chk("rst instr2", bus.instr2, NOP);
    chk("rst pair",   32'(bus.pair_issues), 0);
    rst_n = 1'b1;
    cyc();

    // two back-to-back writes, no pops
    bus.wr_valid = 1'b1; bus.wr_instr = 32'h0020_8133; cyc();
    bus.wr_instr = 32'h0041_8233; cyc();
    bus.wr_valid = 1'b0;
    chk("dir count2", 32'(bus.count), 2);
    chk("dir instr1", bus.instr1, 32'h0020_8133);
    chk("dir instr2", bus.instr2, 32'h0041_8233);
    chk("dir empty0", 32'(bus.instr_queue_empty), 0);

    // du2 alone cannot pop; then dual pop
    bus.dispatch_2_ready = 1'b1; cyc();
    chk("d2 only count", 32'(bus.count), 2);
    bus.dispatch_1_ready = 1'b1; cyc();
    idle();
    chk("dual count", 32'(bus.count), 0);
    chk("dual pair",  32'(bus.pair_issues), 1);
    chk("dual instr1", bus.instr1, NOP);
    chk("dual instr2", bus.instr2, NOP);

    // fill to full, then a dual pop must not admit the held write
    fill(DEPTH);
    chk("full count", 32'(bus.count), DEPTH);
    chk("full wr_ready", 32'(bus.wr_ready), 0);
    bus.wr_valid = 1'b1; bus.wr_instr = 32'hDEAD_BEEF;
    bus.dispatch_1_ready = 1'b1; bus.dispatch_2_ready = 1'b1;
    cyc();
    idle();
    chk("full pop count", 32'(bus.count), DEPTH-2);
    chk("full pop wr_ready", 32'(bus.wr_ready), 1);
    drain();

    // single-entry + push + double request: only pop1, pushed word becomes head
    fill(1);
    bus.wr_valid = 1'b1; bus.wr_instr = 32'hCAFE_0001;
    bus.dispatch_1_ready = 1'b1; bus.dispatch_2_ready = 1'b1;
    cyc();
    idle();
    chk("c1 count", 32'(bus.count), 1);
    chk("c1 head",  bus.instr1, 32'hCAFE_0001);
    drain();

    // 40-word stream across pointer wrap, alternating single and double pops
    for (int i = 0; i < 40; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_instr = $urandom;
      bus.dispatch_1_ready = 1'b1;
      bus.dispatch_2_ready = (i % 2 == 1);
      cyc();
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.dispatch_2_ready = (i % 2 == 1);
      cyc();
    end
    idle();
    chk("stream drained", 32'(bus.count), 0);

    // flush with push and dual pop pending
    fill(5);
    chk("pre-flush count", 32'(bus.count), 5);
    pexp = mpair;
    bus.flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_instr = 32'h1111_2222;
    bus.dispatch_1_ready = 1'b1; bus.dispatch_2_ready = 1'b1;
    cyc();
    idle();
    chk("flush count", 32'(bus.count), 0);
    chk("flush empty", 32'(bus.instr_queue_empty), 1);
    chk("flush pair",  32'(bus.pair_issues), pexp);
    bus.wr_valid = 1'b1; bus.wr_instr = 32'h3333_4444; cyc();
    idle();
    chk("post-flush count", 32'(bus.count), 1);
    chk("post-flush head",  bus.instr1, 32'h3333_4444);
    drain();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.wr_valid         = ($urandom_range(3) != 0);
      bus.wr_instr         = $urandom;
      bus.dispatch_1_ready = ($urandom_range(1) == 1);
      bus.dispatch_2_ready = ($urandom_range(2) != 0);
      bus.flush            = ($urandom_range(31) == 0);
      cyc();
    end
    idle();
    drain();

    // asynchronous reset mid-operation
    fill(7);
    chk("pre-reset count", 32'(bus.count), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async count",    32'(bus.count), 0);
    chk("async wr_ready", 32'(bus.wr_ready), 1);
    chk("async empty",    32'(bus.instr_queue_empty), 1);
    chk("async pair",     32'(bus.pair_issues), 0);
    mq.delete();
    mpair = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // pair_issues saturation: preload near the top, then four dual pops
    fill(8);
    force dut.pair_q = 16'hFFFD;
    #1 release dut.pair_q;
    mpair = 32'hFFFD;
    bus.dispatch_1_ready = 1'b1; bus.dispatch_2_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    idle();
    chk("pair saturate", 32'(bus.pair_issues), 32'hFFFF);
    chk("sat count", 32'(bus.count), 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
